// File: rtl/his_acq_sequencer.sv
// Histogram acquisition sequencer: clears the histogram RAM, forwards DATA_NUM samples per pixel
// per acquisition to the histogram builder, waits for the peak search to drain, then flags peakValid.
module his_acq_sequencer #(
    parameter int NP        = 10,
    parameter int PIXEL_NUM = 3,
    parameter int ACQ_NUM   = 2,
    parameter int DATA_NUM  = 2,
    parameter int CLR_LEN   = 16,
    parameter int PEAK_LAT  = 4,
    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          abort,
    input  logic          tdcValid,
    input  logic [NP-1:0] tdcData,
    output logic          tdcReady,
    output logic          wrEn,
    output logic [NP-1:0] data,
    output logic [PW-1:0] pixelIdx,
    output logic [AW-1:0] acqIdx,
    output logic          histClr,
    output logic          busy,
    output logic          peakValid,
    output logic          dropErr
);
    localparam int SW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(DATA_NUM - 1);
    localparam logic [PW-1:0] PIXEL_LAST  = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] ACQ_LAST    = AW'(ACQ_NUM - 1);
    localparam logic [15:0]   CLR_END     = 16'(CLR_LEN - 1);
    localparam logic [15:0]   DRAIN_END   = 16'(PEAK_LAT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, DRAIN, DONE} stateT;

    stateT         state;
    stateT         nextState;
    logic [SW-1:0] sampleCnt;
    logic [PW-1:0] pixelCnt;
    logic [AW-1:0] acqCnt;
    logic [15:0]   cycCnt;
    logic          xfer;
    logic          lastXfer;
    logic          frameStart;

    always_comb begin
        // NOTE: every signal of this block is given a default first, so no path can infer a latch.
        nextState  = state;
        tdcReady   = (state == COLLECT);
        histClr    = (state == CLEAR);
        peakValid  = (state == DONE);
        busy       = (state != IDLE);
        xfer       = tdcValid && tdcReady;
        lastXfer   = xfer && (sampleCnt == SAMPLE_LAST) && (pixelCnt == PIXEL_LAST)
                     && (acqCnt == ACQ_LAST);
        if (abort) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nextState = CLEAR;
                CLEAR:   if (cycCnt == CLR_END) nextState = COLLECT;
                COLLECT: if (lastXfer) nextState = DRAIN;
                DRAIN:   if (cycCnt == DRAIN_END) nextState = DONE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
        frameStart = (state == IDLE) && (nextState == CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= nextState;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sampleCnt <= '0;
            pixelCnt  <= '0;
            acqCnt    <= '0;
            cycCnt    <= '0;
            wrEn      <= 1'b0;
            data      <= '0;
            pixelIdx  <= '0;
            acqIdx    <= '0;
            dropErr   <= 1'b0;
        end else begin
            wrEn   <= 1'b0;
            // Cycles spent in the current state; only CLEAR and DRAIN look at it.
            cycCnt <= (nextState != state) ? '0 : cycCnt + 16'd1;

            if (frameStart) begin
                sampleCnt <= '0;
                pixelCnt  <= '0;
                acqCnt    <= '0;
                dropErr   <= 1'b0;
            end else if (tdcValid && !tdcReady && busy) begin
                dropErr <= 1'b1;
            end

            // An abort on the transfer cycle discards the sample entirely.
            if (xfer && !abort) begin
                wrEn     <= 1'b1;
                data     <= tdcData;
                pixelIdx <= pixelCnt;
                acqIdx   <= acqCnt;
                if (sampleCnt == SAMPLE_LAST) begin
                    sampleCnt <= '0;
                    if (pixelCnt == PIXEL_LAST) begin
                        pixelCnt <= '0;
                        acqCnt   <= (acqCnt == ACQ_LAST) ? '0 : acqCnt + 1'b1;
                    end else begin
                        pixelCnt <= pixelCnt + 1'b1;
                    end
                end else begin
                    sampleCnt <= sampleCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Directed bench for his_acq_sequencer at default parameters; each scenario task checks its own
// expectations against hand-computed tables.
module tb_his_acq_sequencer;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       tdcValid = 1'b0;
    logic [9:0] tdcData = '0;
    logic       tdcReady, wrEn, histClr, busy, peakValid, dropErr;
    logic [9:0] data;
    logic [1:0] pixelIdx;
    logic [0:0] acqIdx;

    his_acq_sequencer dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .tdcValid(tdcValid), .tdcData(tdcData), .tdcReady(tdcReady),
        .wrEn(wrEn), .data(data), .pixelIdx(pixelIdx), .acqIdx(acqIdx),
        .histClr(histClr), .busy(busy), .peakValid(peakValid), .dropErr(dropErr)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    logic [9:0] samples [12] = '{10'd108, 10'd511, 10'd1022, 10'd1022, 10'd200, 10'd90,
                                 10'd511, 10'd1023, 10'd90, 10'd90, 10'd90, 10'd1023};
    logic [0:0] expAcq  [12] = '{1'd0, 1'd0, 1'd0, 1'd0, 1'd0, 1'd0,
                                 1'd1, 1'd1, 1'd1, 1'd1, 1'd1, 1'd1};
    logic [1:0] expPix  [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};

    // Observation log taken on the falling edge: writes as {data, acqIdx, pixelIdx}.
    int          cyc = 0;
    logic [12:0] wrLog [$];
    int          wrCyc [$];
    int          xfCyc [$];
    int          clrCnt = 0;
    int          peakCnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrEn) begin
            wrLog.push_back({data, acqIdx, pixelIdx});
            wrCyc.push_back(cyc);
        end
        if (tdcValid && tdcReady && !abort && res) xfCyc.push_back(cyc);
        if (histClr) clrCnt <= clrCnt + 1;
        if (peakValid) peakCnt <= peakCnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startFrame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitReady(input int maxCyc, output bit ok);
        int n = 0;
        while (!tdcReady && n < maxCyc) begin
            tick();
            n++;
        end
        ok = tdcReady;
    endtask

    task automatic waitIdle(input int maxCyc, output bit ok);
        int n = 0;
        while (busy && n < maxCyc) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    // Presents the twelve samples, optionally with tdcValid toggling every cycle.
    task automatic feed(input bit bubbly, output bit ok);
        int idx = 0;
        int n = 0;
        bit ph = 1'b1;
        bit rdy;
        while (idx < 12 && n < 200) begin
            tdcValid = bubbly ? ph : 1'b1;
            tdcData  = samples[idx];
            ph       = !ph;
            rdy      = tdcReady;
            tick();
            n++;
            if (tdcValid && rdy) idx++;
        end
        tdcValid = 1'b0;
        ok = (idx == 12);
    endtask

    task automatic test_reset();
        #1 res = 1'b0;
        #2;
        nCompared++;
        if ({tdcReady, wrEn, histClr, busy, peakValid, dropErr} !== 6'b0) begin
            nMismatch++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {tdcReady, wrEn, histClr, busy, peakValid, dropErr});
        end
        nCompared++;
        if ({data, acqIdx, pixelIdx} !== 13'd0) begin
            nMismatch++;
            $display("FAIL reset_data: got %h, expected 0", {data, acqIdx, pixelIdx});
        end
        @(posedge clk);
        #1;
        res   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        nCompared++;
        if ({busy, histClr} !== 2'b11) begin
            nMismatch++;
            $display("FAIL reset_first_start: busy,histClr got %b, expected 11", {busy, histClr});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nCompared++;
        if ({busy, histClr} !== 2'b00) begin
            nMismatch++;
            $display("FAIL reset_abort_clear: busy,histClr got %b, expected 00", {busy, histClr});
        end
    endtask

    task automatic test_full_frame();
        int b = wrLog.size();
        int x = xfCyc.size();
        int c0 = clrCnt;
        int p0 = peakCnt;
        bit ok;
        startFrame();
        waitReady(40, ok);
        nCompared++;
        if (!ok) begin
            nMismatch++;
            $display("FAIL full_ready_timeout: tdcReady got 0, expected 1");
        end
        nCompared++;
        if (clrCnt - c0 !== 16) begin
            nMismatch++;
            $display("FAIL full_clr_len: got %0d cycles, expected 16", clrCnt - c0);
        end
        feed(1'b0, ok);
        nCompared++;
        if (!ok) begin
            nMismatch++;
            $display("FAIL full_feed_timeout: transfers incomplete, expected 12");
        end
        nCompared++;
        if ({wrEn, tdcReady, busy} !== 3'b101) begin
            nMismatch++;
            $display("FAIL full_drain_entry: wrEn,tdcReady,busy got %b, expected 101",
                     {wrEn, tdcReady, busy});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++;
            if ({peakValid, busy} !== 2'b01) begin
                nMismatch++;
                $display("FAIL full_drain_%0d: peakValid,busy got %b, expected 01", i, {peakValid, busy});
            end
        end
        tick();
        nCompared++;
        if (peakValid !== 1'b1) begin
            nMismatch++;
            $display("FAIL full_peak: peakValid got %b, expected 1", peakValid);
        end
        tick();
        nCompared++;
        if ({peakValid, busy, wrEn} !== 3'b000) begin
            nMismatch++;
            $display("FAIL full_idle: peakValid,busy,wrEn got %b, expected 000", {peakValid, busy, wrEn});
        end
        nCompared++;
        if (peakCnt - p0 !== 1) begin
            nMismatch++;
            $display("FAIL full_peak_count: got %0d, expected 1", peakCnt - p0);
        end
        nCompared++;
        if (wrLog.size() - b !== 12 || xfCyc.size() - x !== 12) begin
            nMismatch++;
            $display("FAIL full_write_count: got %0d writes, %0d transfers, expected 12",
                     wrLog.size() - b, xfCyc.size() - x);
        end else begin
            for (int i = 0; i < 12; i++) begin
                nCompared++;
                if (wrLog[b+i] !== {samples[i], expAcq[i], expPix[i]}) begin
                    nMismatch++;
                    $display("FAIL full_write_%0d: {data,acq,pix} got %h, expected %h", i,
                             wrLog[b+i], {samples[i], expAcq[i], expPix[i]});
                end
                nCompared++;
                if (wrCyc[b+i] !== xfCyc[x+i] + 1) begin
                    nMismatch++;
                    $display("FAIL full_latency_%0d: got %0d cycles, expected 1", i,
                             wrCyc[b+i] - xfCyc[x+i]);
                end
            end
        end
        nCompared++;
        if ({dropErr, data} !== {1'b0, 10'd1023}) begin
            nMismatch++;
            $display("FAIL full_hold: dropErr,data got %b,%0d, expected 0,1023", dropErr, data);
        end
    endtask

    task automatic test_bubbly();
        int b = wrLog.size();
        int p0 = peakCnt;
        bit ok;
        bit ok2;
        startFrame();
        waitReady(40, ok);
        feed(1'b1, ok2);
        nCompared++;
        if (!(ok && ok2)) begin
            nMismatch++;
            $display("FAIL bubbly_timeout: ready %b feed %b, expected 1 1", ok, ok2);
        end
        waitIdle(20, ok);
        nCompared++;
        if (!ok || peakCnt - p0 !== 1) begin
            nMismatch++;
            $display("FAIL bubbly_end: idle %b peaks %0d, expected 1 1", ok, peakCnt - p0);
        end
        nCompared++;
        if (wrLog.size() - b !== 12) begin
            nMismatch++;
            $display("FAIL bubbly_write_count: got %0d, expected 12", wrLog.size() - b);
        end else begin
            for (int i = 0; i < 12; i++) begin
                nCompared++;
                if (wrLog[b+i] !== {samples[i], expAcq[i], expPix[i]}) begin
                    nMismatch++;
                    $display("FAIL bubbly_write_%0d: {data,acq,pix} got %h, expected %h", i,
                             wrLog[b+i], {samples[i], expAcq[i], expPix[i]});
                end
            end
        end
        nCompared++;
        if (dropErr !== 1'b0) begin
            nMismatch++;
            $display("FAIL bubbly_drop: dropErr got %b, expected 0", dropErr);
        end
    endtask

    task automatic test_abort();
        int b = wrLog.size();
        int b2;
        int p0;
        bit ok;
        startFrame();
        waitReady(40, ok);
        tdcValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdcData = samples[i];
            tick();
        end
        tdcData = samples[4];
        abort   = 1'b1;
        tick();
        abort    = 1'b0;
        tdcValid = 1'b0;
        nCompared++;
        if ({busy, tdcReady, wrEn} !== 3'b000) begin
            nMismatch++;
            $display("FAIL abort_idle: busy,tdcReady,wrEn got %b, expected 000", {busy, tdcReady, wrEn});
        end
        nCompared++;
        if (wrLog.size() - b !== 4) begin
            nMismatch++;
            $display("FAIL abort_writes: got %0d, expected 4", wrLog.size() - b);
        end
        b2 = wrLog.size();
        p0 = peakCnt;
        startFrame();
        waitReady(40, ok);
        feed(1'b0, ok);
        waitIdle(20, ok);
        nCompared++;
        if (wrLog.size() - b2 !== 12 || peakCnt - p0 !== 1) begin
            nMismatch++;
            $display("FAIL abort_rerun: writes %0d peaks %0d, expected 12 1", wrLog.size() - b2, peakCnt - p0);
        end else begin
            nCompared++;
            if (wrLog[b2] !== {10'd108, 1'b0, 2'd0} || wrLog[b2+11] !== {10'd1023, 1'b1, 2'd2}) begin
                nMismatch++;
                $display("FAIL abort_rerun_idx: first %h last %h, expected %h %h", wrLog[b2],
                         wrLog[b2+11], {10'd108, 1'b0, 2'd0}, {10'd1023, 1'b1, 2'd2});
            end
        end
    endtask

    task automatic test_drop_clear();
        int b = wrLog.size();
        bit ok;
        startFrame();
        tdcValid = 1'b1;
        tick();
        tdcValid = 1'b0;
        nCompared++;
        if ({dropErr, wrEn} !== 2'b10) begin
            nMismatch++;
            $display("FAIL drop_set: dropErr,wrEn got %b, expected 10", {dropErr, wrEn});
        end
        waitReady(40, ok);
        feed(1'b0, ok);
        waitIdle(20, ok);
        tick();
        nCompared++;
        if ({dropErr, busy} !== 2'b10 || wrLog.size() - b !== 12) begin
            nMismatch++;
            $display("FAIL drop_sticky: dropErr,busy got %b writes %0d, expected 10 12",
                     {dropErr, busy}, wrLog.size() - b);
        end
        startFrame();
        nCompared++;
        if ({dropErr, busy} !== 2'b01) begin
            nMismatch++;
            $display("FAIL drop_clear_on_start: dropErr,busy got %b, expected 01", {dropErr, busy});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p0 = peakCnt;
        bit ok;
        startFrame();
        waitReady(40, ok);
        tdcValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tdcData = samples[i];
            tick();
        end
        #2 res = 1'b0;
        #1;
        nCompared++;
        if ({tdcReady, wrEn, histClr, busy, peakValid, dropErr} !== 6'b0) begin
            nMismatch++;
            $display("FAIL midreset_flags: got %b, expected 000000",
                     {tdcReady, wrEn, histClr, busy, peakValid, dropErr});
        end
        nCompared++;
        if ({data, acqIdx, pixelIdx} !== 13'd0) begin
            nMismatch++;
            $display("FAIL midreset_data: got %h, expected 0", {data, acqIdx, pixelIdx});
        end
        tdcValid = 1'b0;
        @(posedge clk);
        #1;
        res   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        nCompared++;
        if ({busy, histClr} !== 2'b11 || peakCnt !== p0) begin
            nMismatch++;
            $display("FAIL midreset_restart: busy,histClr got %b peaks %0d, expected 11 0",
                     {busy, histClr}, peakCnt - p0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_start_held();
        int b = wrLog.size();
        int n = 0;
        bit ok;
        start = 1'b1;
        tick();
        waitReady(40, ok);
        feed(1'b0, ok);
        while (!peakValid && n < 20) begin
            tick();
            n++;
        end
        nCompared++;
        if (peakValid !== 1'b1 || wrLog.size() - b !== 12) begin
            nMismatch++;
            $display("FAIL held_frame: peakValid %b writes %0d, expected 1 12", peakValid, wrLog.size() - b);
        end
        tick();
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("FAIL held_idle: busy got %b, expected 0", busy);
        end
        tick();
        nCompared++;
        if ({busy, histClr} !== 2'b11) begin
            nMismatch++;
            $display("FAIL held_restart: busy,histClr got %b, expected 11", {busy, histClr});
        end
        abort = 1'b1;
        tick();
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("FAIL held_abort: busy got %b, expected 0", busy);
        end
        tick(2);
        nCompared++;
        if ({busy, histClr} !== 2'b00) begin
            nMismatch++;
            $display("FAIL start_abort_idle: busy,histClr got %b, expected 00", {busy, histClr});
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_bubbly();
        test_abort();
        test_drop_clear();
        test_reset_mid();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
